// File: rtl/loop_seq_6bit_if.sv
// Step/handshake bundle between the frame controller (master) and the
// two-level loop sequencer (slave).
interface loop_seq_6bit_if #(parameter int CNT_WIDTH = 6) ();
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] inner_last;
    logic [CNT_WIDTH-1:0] outer_last;
    logic                 step_ready;
    logic                 step_valid;
    logic [CNT_WIDTH-1:0] inner_idx;
    logic [CNT_WIDTH-1:0] outer_idx;
    logic                 last_inner;
    logic                 last_step;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, inner_last, outer_last, step_ready,
        input  step_valid, inner_idx, outer_idx, last_inner, last_step, busy, done
    );

    modport slave (
        input  start, abort, inner_last, outer_last, step_ready,
        output step_valid, inner_idx, outer_idx, last_inner, last_step, busy, done
    );
endinterface

// File: rtl/loop_seq_6bit.sv
// Two-level (outer, inner) loop sequencer presenting one step per
// valid/ready handshake and pulsing done once the last step is taken.
module loop_seq_6bit #(
    parameter int CNT_WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    loop_seq_6bit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] inner_q, inner_d;
    logic [CNT_WIDTH-1:0] outer_q, outer_d;
    logic [CNT_WIDTH-1:0] inner_last_q, inner_last_d;
    logic [CNT_WIDTH-1:0] outer_last_q, outer_last_d;

    logic [CNT_WIDTH-1:0] inner_eq_bits;
    logic [CNT_WIDTH-1:0] outer_eq_bits;
    logic                 inner_at_last;
    logic                 outer_at_last;
    logic                 accept;

    // Per-bit equality against the latched limits only, never the live inputs.
    for (genvar gi = 0; gi < CNT_WIDTH; gi++) begin : g_eq
        assign inner_eq_bits[gi] = ~(inner_q[gi] ^ inner_last_q[gi]);
        assign outer_eq_bits[gi] = ~(outer_q[gi] ^ outer_last_q[gi]);
    end

    assign inner_at_last = &inner_eq_bits;
    assign outer_at_last = &outer_eq_bits;
    assign accept        = (state_q == RUN) && bus.step_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            inner_q      <= '0;
            outer_q      <= '0;
            inner_last_q <= '0;
            outer_last_q <= '0;
        end else begin
            state_q      <= state_d;
            inner_q      <= inner_d;
            outer_q      <= outer_d;
            inner_last_q <= inner_last_d;
            outer_last_q <= outer_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        inner_d      = inner_q;
        outer_d      = outer_q;
        inner_last_d = inner_last_q;
        outer_last_d = outer_last_q;

        if (bus.abort) begin
            // Abort wins over start and over a same-cycle accept.
            state_d = IDLE;
            inner_d = '0;
            outer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        inner_last_d = bus.inner_last;
                        outer_last_d = bus.outer_last;
                        inner_d      = '0;
                        outer_d      = '0;
                        state_d      = RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!inner_at_last) begin
                            inner_d = CNT_WIDTH'(inner_q + 1'b1);
                        end else if (!outer_at_last) begin
                            inner_d = '0;
                            outer_d = CNT_WIDTH'(outer_q + 1'b1);
                        end else begin
                            // Final step taken: indices keep their last values.
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.step_valid = (state_q == RUN);
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.inner_idx  = inner_q;
    assign bus.outer_idx  = outer_q;
    assign bus.last_inner = (state_q == RUN) && inner_at_last;
    assign bus.last_step  = (state_q == RUN) && inner_at_last && outer_at_last;

endmodule

// File: doc/loop_seq_6bit.md
# loop_seq_6bit

Two-level loop sequencer that drives the iteration side of the 6-bit loop-counter interface. It walks an outer index and an inner index over programmable ranges and presents one (outer, inner) step per valid/ready handshake. It reports completion with a one-cycle done pulse. It sits between the top-level frame controller and the per-step datapath, for example filter-bank × bin loops, replacing ad-hoc enable/over chaining of separate counters.

## Interface
- CNT_WIDTH, 6, width of both indices and both limits
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a sequence; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE without done
- inner_last  input  CNT_WIDTH  last inner index (range 0..inner_last)
- outer_last  input  CNT_WIDTH  last outer index (range 0..outer_last)
- step_ready  input  1  downstream accepts the current step
- step_valid  output  1  current step is valid
- inner_idx  output  CNT_WIDTH  current inner index
- outer_idx  output  CNT_WIDTH  current outer index
- last_inner  output  1  inner_idx == latched inner_last, gated by step_valid
- last_step  output  1  last_inner and outer_idx == latched outer_last, gated by step_valid
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at completion

## Operation
- States: IDLE, RUN, DONE. State and all registers clear asynchronously on rst_n low.
- IDLE:
  - If start=1 and abort=0: latch inner_last and outer_last, clear both indices, go to RUN.
  - Limit inputs are ignored at all other times; changing them mid-run has no effect.
- RUN:
  - step_valid=1. The step is accepted on any cycle with step_valid & step_ready.
  - On accept with inner_idx != inner_last_q: inner_idx+1.
  - On accept with inner_idx == inner_last_q and outer_idx != outer_last_q: inner_idx←0, outer_idx+1.
  - On accept at the last step: go to DONE. Indices hold their final values.
  - Without step_ready: state, indices, and step_valid hold (no-drop rule).
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- abort=1 in any state: next state IDLE, indices clear, no done pulse. abort overrides start and overrides an accept in the same cycle.
- Total accepted steps = (inner_last+1)·(outer_last+1). A zero limit is legal: 0,0 gives exactly one step.
- Indices never exceed the latched limits. There is no modular wrap beyond the limit, so all-ones limits (63) are legal and produce 64 iterations per level.
- The limit comparisons use the latched copies only.
- Reset values: step_valid=0, inner_idx=0, outer_idx=0, last_inner=0, last_step=0, busy=0, done=0.

## Timing
- start high in cycle t (IDLE): busy and step_valid are high from t+1, and step (0,0) is presented at t+1.
- With step_ready held high, there is one step per cycle and no bubbles at inner wrap.
- Final accept in cycle f: step_valid and busy are low at f+1, done is high at f+1 only, and the state is IDLE at f+2.
- Earliest restart is start at f+2, giving a first step at f+3.
- All outputs are registered or decoded from registered state only. There is no combinational path from step_ready or start to any output.
- abort in cycle a: all outputs are at reset values from a+1.
- rst_n asserted mid-sequence: outputs clear immediately (asynchronously). After release, the block waits in IDLE for a new start.

## Test plan
- Basic sweep: inner_last=2, outer_last=1, step_ready=1, start pulse → 6 steps (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on consecutive cycles. last_inner is high on inner=2. last_step is high on (1,2) only. done pulses 1 cycle after (1,2).
- Backpressure: same limits, step_ready toggling 1,0,0,1,… → each step holds stable while ready=0. There are still exactly 6 accepts, and no index is skipped or repeated.
- Boundaries:
  - limits 0,0 → a single step (0,0) with last_step=1, then done.
  - limits 63,63 → 4096 accepts, indices reach 63, and there is no wrap to 0 before done.
- Limit change and ignored start: change inner_last from 2 to 5 mid-run, and pulse start during RUN and during DONE → the sequence still uses 2, no restart occurs, and done pulses once.
- Abort: abort asserted at step (1,0) together with step_ready=1 → IDLE next cycle, indices 0, no done. A start 2 cycles later runs a full fresh sequence.
- Reset mid-run: rst_n low at step (0,1) → all outputs 0 asynchronously. After release the block stays idle with step_valid=0 until start.
